// File: rtl/fir_channel_scheduler.sv
// Round-robin scheduler that time-shares one FIR datapath between NUM_CH channels.
// Each grant streams one burst into the filter, then flushes the filter tail before the next grant.
module fir_channel_scheduler #(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned OUT_WIDTH    = 33,
  parameter int unsigned DRAIN_CYCLES = 17,
  parameter int unsigned MAX_BURST    = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CH-1:0]          req_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_CH-1:0]          req_last,
  output logic [NUM_CH-1:0]          req_ready,
  output logic [DATA_WIDTH-1:0]      flt_in,
  output logic                       flt_valid,
  input  logic [OUT_WIDTH-1:0]       flt_out,
  input  logic                       flt_valid_out,
  output logic [OUT_WIDTH-1:0]       out_data,
  output logic                       out_valid,
  output logic [$clog2(NUM_CH)-1:0]  out_chan,
  output logic                       out_last,
  output logic                       busy
);

  localparam int unsigned ChW    = $clog2(NUM_CH);
  localparam int unsigned BurstW = $clog2(MAX_BURST + 1);
  localparam int unsigned DrainW = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StStream, StDrain} state_e;

  state_e            state_q, state_d;
  logic [ChW-1:0]    owner_q, owner_d;
  logic [ChW-1:0]    last_grant_q, last_grant_d;
  logic [BurstW-1:0] burst_cnt_q, burst_cnt_d;
  logic [DrainW-1:0] drain_cnt_q, drain_cnt_d;

  logic              grant_found;
  logic [ChW-1:0]    grant_idx;
  logic              room;
  logic              accept;
  logic              burst_end;

  // First requester strictly after last_grant, wrapping around.
  always_comb begin
    int unsigned cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      cand = (32'(last_grant_q) + k) % NUM_CH;
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = ChW'(cand);
      end
    end
  end

  assign room      = (state_q == StStream) && (burst_cnt_q < BurstW'(MAX_BURST));
  assign accept    = room && req_valid[owner_q];
  assign burst_end = accept &&
                     (req_last[owner_q] || (burst_cnt_q == BurstW'(MAX_BURST - 1)));

  always_comb begin
    req_ready = '0;
    if (room) begin
      req_ready[owner_q] = 1'b1;
    end
    flt_valid = accept;
    flt_in    = accept ? req_data[32'(owner_q) * DATA_WIDTH +: DATA_WIDTH] : '0;
    busy      = (state_q != StIdle);
    out_valid = flt_valid_out && busy;
    out_data  = out_valid ? flt_out : '0;
    out_chan  = out_valid ? owner_q : '0;
    out_last  = out_valid && (state_q == StDrain) && (drain_cnt_q == DrainW'(1));
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    burst_cnt_d  = burst_cnt_q;
    drain_cnt_d  = drain_cnt_q;
    case (state_q)
      StIdle: begin
        if (grant_found) begin
          owner_d     = grant_idx;
          burst_cnt_d = '0;
          state_d     = StStream;
        end
      end
      StStream: begin
        if (accept) begin
          burst_cnt_d = burst_cnt_q + BurstW'(1);
        end
        if (burst_end) begin
          state_d      = StDrain;
          drain_cnt_d  = DrainW'(DRAIN_CYCLES);
          last_grant_d = owner_q;
        end
      end
      StDrain: begin
        drain_cnt_d = drain_cnt_q - DrainW'(1);
        if (drain_cnt_q == DrainW'(1)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      owner_q      <= '0;
      last_grant_q <= ChW'(NUM_CH - 1);
      burst_cnt_q  <= '0;
      drain_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      burst_cnt_q  <= burst_cnt_d;
      drain_cnt_q  <= drain_cnt_d;
    end
  end

endmodule

// File: tb/tb_fir_channel_scheduler.sv
// Directed bench for fir_channel_scheduler: per-channel sample queues drive the requests,
// a scoreboard of expected accepts / burst ends / impulse taps checks the outputs.
module tb_fir_channel_scheduler;

  localparam int NCH  = 4;
  localparam int DW   = 16;
  localparam int OW   = 33;
  localparam int NTAP = 17;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NCH-1:0]    req_valid = '0;
  logic [NCH*DW-1:0] req_data  = '0;
  logic [NCH-1:0]    req_last  = '0;
  logic [NCH-1:0]    req_ready;
  logic [DW-1:0]     flt_in;
  logic              flt_valid;
  logic [OW-1:0]     flt_out;
  logic              flt_valid_out = 1'b1;
  logic [OW-1:0]     out_data;
  logic              out_valid;
  logic [1:0]        out_chan;
  logic              out_last;
  logic              busy;

  fir_channel_scheduler dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .flt_in        (flt_in),
    .flt_valid     (flt_valid),
    .flt_out       (flt_out),
    .flt_valid_out (flt_valid_out),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_chan      (out_chan),
    .out_last      (out_last),
    .busy          (busy)
  );

  // Simple 17-tap filter model; not reset, like a real datapath behind the scheduler.
  logic signed [DW-1:0] tap [NTAP] = '{default: '0};

  function automatic int coef(input int k);
    return 100 + 7 * k;
  endfunction

  always @(posedge clk) begin
    tap[0] <= flt_valid ? flt_in : '0;
    for (int k = 1; k < NTAP; k++) tap[k] <= tap[k-1];
  end

  always_comb begin
    logic signed [OW-1:0] sum;
    sum = '0;
    for (int k = 0; k < NTAP; k++) sum = sum + OW'(coef(k) * 32'(tap[k]));
    flt_out = sum;
  end

  typedef struct packed {logic bubble; logic last; logic [DW-1:0] data;} samp_t;
  typedef struct packed {logic [1:0] chan; logic [DW-1:0] data;} acc_t;

  samp_t      chq [NCH][$];
  acc_t       exp_acc[$];
  logic [1:0] exp_last[$];
  logic [OW-1:0] exp_imp[$];

  int tests = 0;
  int fails = 0;
  int busy_cyc = 0;
  logic busy_seen;
  logic [NCH-1:0] hs;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ready"}, 64'(req_ready), 64'(0));
    chk({tag, "_flt_valid"}, 64'(flt_valid), 64'(0));
    chk({tag, "_flt_in"}, 64'(flt_in), 64'(0));
    chk({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    chk({tag, "_out_data"}, 64'(out_data), 64'(0));
    chk({tag, "_out_chan"}, 64'(out_chan), 64'(0));
    chk({tag, "_out_last"}, 64'(out_last), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
  endtask

  task automatic drive();
    for (int i = 0; i < NCH; i++) begin
      if (chq[i].size() > 0 && !chq[i][0].bubble) begin
        req_valid[i]            = 1'b1;
        req_last[i]             = chq[i][0].last;
        req_data[i*DW +: DW]    = chq[i][0].data;
      end else begin
        req_valid[i]            = 1'b0;
        req_last[i]             = 1'b0;
        req_data[i*DW +: DW]    = '0;
      end
    end
  endtask

  task automatic monitor();
    logic [1:0] ch;
    acc_t e;
    busy_seen = busy;
    if (busy) busy_cyc++;
    if (flt_valid) begin
      ch = '0;
      for (int i = 0; i < NCH; i++) if (req_ready[i]) ch = 2'(i);
      chk("ready_onehot", 64'($countones(req_ready)), 64'(1));
      chk("accept_expected", 64'(exp_acc.size() != 0), 64'(1));
      if (exp_acc.size() != 0) begin
        e = exp_acc.pop_front();
        chk("accept_chan", 64'(ch), 64'(e.chan));
        chk("accept_data", 64'(flt_in), 64'(e.data));
      end
    end
    if (out_last) begin
      chk("last_expected", 64'(exp_last.size() != 0), 64'(1));
      if (exp_last.size() != 0) chk("last_chan", 64'(out_chan), 64'(exp_last.pop_front()));
    end
    if (exp_imp.size() > 0 && out_valid && !flt_valid) begin
      chk("imp_data", 64'(out_data), 64'(exp_imp.pop_front()));
      chk("imp_chan", 64'(out_chan), 64'(3));
    end
    hs = req_valid & req_ready;
  endtask

  task automatic step();
    @(negedge clk);
    drive();
    #1;
    monitor();
    @(posedge clk);
    for (int i = 0; i < NCH; i++) begin
      if (hs[i]) void'(chq[i].pop_front());
      else if (chq[i].size() > 0 && chq[i][0].bubble) void'(chq[i].pop_front());
    end
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NCH; i++) if (chq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic run(input string tag, input int budget);
    bit done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      step();
      done = all_empty() && !busy_seen;
    end
    chk({tag, "_completes"}, 64'(done), 64'(1));
    chk({tag, "_acc_drained"}, 64'(exp_acc.size()), 64'(0));
    chk({tag, "_last_drained"}, 64'(exp_last.size()), 64'(0));
  endtask

  task automatic send(input int ch, input int n, input int base, input bit last_at_end);
    for (int k = 0; k < n; k++)
      chq[ch].push_back('{bubble: 1'b0, last: last_at_end && (k == n - 1), data: DW'(base + k)});
  endtask

  task automatic expect_acc(input int ch, input int n, input int base);
    for (int k = 0; k < n; k++) exp_acc.push_back('{chan: 2'(ch), data: DW'(base + k)});
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    drive();
    #1;
    check_zero(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset with a pending request: nothing may be granted or forwarded.
    send(2, 1, 'h55, 1'b1);
    drive();
    #12;
    check_zero("reset");
    chq[2].delete();
    drive();
    @(negedge clk);
    rst_n = 1'b1;

    // Single channel burst of 5.
    busy_cyc = 0;
    send(1, 5, 'h100, 1'b1);
    expect_acc(1, 5, 'h100);
    exp_last.push_back(2'd1);
    run("single", 100);
    chk("single_busy_cycles", 64'(busy_cyc), 64'(22));

    // Round robin from a fresh pointer: 0,1,2,3,0.
    do_reset("reset2");
    busy_cyc = 0;
    send(0, 3, 'h200, 1'b1);
    send(1, 3, 'h210, 1'b1);
    send(2, 3, 'h220, 1'b1);
    send(3, 3, 'h230, 1'b1);
    send(0, 3, 'h240, 1'b1);
    expect_acc(0, 3, 'h200);
    expect_acc(1, 3, 'h210);
    expect_acc(2, 3, 'h220);
    expect_acc(3, 3, 'h230);
    expect_acc(0, 3, 'h240);
    for (int c = 0; c < 5; c++) exp_last.push_back(2'(c % 4));
    run("rr", 400);
    chk("rr_busy_cycles", 64'(busy_cyc), 64'(100));

    // Forced end after MAX_BURST; ch2 comes back only after ch3 and ch0.
    busy_cyc = 0;
    send(2, 70, 'h1000, 1'b1);
    send(3, 2, 'h300, 1'b1);
    send(0, 2, 'h310, 1'b1);
    expect_acc(2, 64, 'h1000);
    expect_acc(3, 2, 'h300);
    expect_acc(0, 2, 'h310);
    expect_acc(2, 6, 'h1040);
    exp_last.push_back(2'd2);
    exp_last.push_back(2'd3);
    exp_last.push_back(2'd0);
    exp_last.push_back(2'd2);
    run("forced", 600);
    chk("forced_busy_cycles", 64'(busy_cyc), 64'(142));

    // Bubbles inside a burst keep the grant.
    busy_cyc = 0;
    chq[0].push_back('{bubble: 1'b0, last: 1'b0, data: DW'('h50)});
    chq[0].push_back('{bubble: 1'b1, last: 1'b0, data: '0});
    chq[0].push_back('{bubble: 1'b1, last: 1'b0, data: '0});
    chq[0].push_back('{bubble: 1'b0, last: 1'b1, data: DW'('h51)});
    expect_acc(0, 1, 'h50);
    expect_acc(0, 1, 'h51);
    exp_last.push_back(2'd0);
    run("bubble", 100);
    chk("bubble_busy_cycles", 64'(busy_cyc), 64'(21));

    // Reset while draining (drain_cnt == 8): burst abandoned, pointer back to channel 0.
    send(1, 1, 'h77, 1'b1);
    expect_acc(1, 1, 'h77);
    for (int c = 0; c < 20 && exp_acc.size() > 0; c++) step();
    chk("rstdrain_accepted", 64'(exp_acc.size()), 64'(0));
    repeat (9) step();
    send(2, 1, 'h410, 1'b1);
    send(0, 2, 'h400, 1'b1);
    do_reset("rstdrain");
    expect_acc(0, 2, 'h400);
    expect_acc(2, 1, 'h410);
    exp_last.push_back(2'd0);
    exp_last.push_back(2'd2);
    run("after_rst", 200);

    // Impulse on ch3 reproduces the coefficients.
    send(3, 1, 1, 1'b1);
    expect_acc(3, 1, 1);
    exp_last.push_back(2'd3);
    for (int k = 0; k < NTAP; k++) exp_imp.push_back(OW'(coef(k)));
    run("impulse", 100);
    chk("impulse_drained", 64'(exp_imp.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fir_channel_scheduler.md
FIR_CHANNEL_SCHEDULER -- requirements
Module: fir_channel_scheduler

Interface
REQ-001 Parameter NUM_CH, default 4: number of requesting channels sharing one FIR datapath.
REQ-002 Parameter DATA_WIDTH, default 16: sample width.
REQ-003 Parameter OUT_WIDTH, default 33: filter result width.
REQ-004 Parameter DRAIN_CYCLES, default 17: zero-input cycles needed to flush the filter tail (equals tap count).
REQ-005 Parameter MAX_BURST, default 64: max samples accepted per grant.
REQ-006 Port clk, input, 1: clock, all state on rising edge.
REQ-007 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-008 Port req_valid, input, NUM_CH: per-channel sample valid.
REQ-009 Port req_data, input, NUM_CH*DATA_WIDTH: per-channel signed sample, channel i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 Port req_last, input, NUM_CH: per-channel end-of-burst marker, qualified by valid&ready.
REQ-011 Port req_ready, output, NUM_CH: per-channel accept.
REQ-012 Port flt_in, output, DATA_WIDTH: sample to filter FilterIn.
REQ-013 Port flt_valid, output, 1: drives filter ValidIn.
REQ-014 Port flt_out, input, OUT_WIDTH: filter data_out.
REQ-015 Port flt_valid_out, input, 1: filter ValidOut.
REQ-016 Port out_data, output, OUT_WIDTH: forwarded filter result.
REQ-017 Port out_valid, output, 1: out_data valid.
REQ-018 Port out_chan, output, clog2(NUM_CH): owning channel of out_data.
REQ-019 Port out_last, output, 1: final result of a burst.
REQ-020 Port busy, output, 1: high whenever state is not IDLE.

Function
REQ-021 States IDLE, STREAM, DRAIN; one owner register; round-robin pointer last_grant.
REQ-022 IDLE: if any req_valid, select first requesting channel strictly after last_grant (wrapping), load owner, clear burst_cnt, go STREAM next cycle; no sample accepted in IDLE.
REQ-023 req_ready[i] combinational = (state==STREAM) && (owner==i) && (burst_cnt<MAX_BURST); all other bits 0.
REQ-024 Accept = req_valid[owner] && req_ready[owner]; on accept flt_valid=1, flt_in=req_data[owner], burst_cnt increments; otherwise flt_valid=0, flt_in=0.
REQ-025 STREAM -> DRAIN when accept with req_last[owner]=1, or when accept brings burst_cnt to MAX_BURST (forced end); load drain_cnt=DRAIN_CYCLES, last_grant=owner.
REQ-026 Owner bubbles in STREAM (req_valid low): stay STREAM, no timeout.
REQ-027 DRAIN: flt_valid=0, flt_in=0, req_ready=0; drain_cnt decrements per cycle; at drain_cnt==1 go IDLE next cycle.
REQ-028 out_valid = flt_valid_out && state in {STREAM, DRAIN}; out_data=flt_out, out_chan=owner, combinational pass-through; out_data=0, out_chan=0 when out_valid=0.
REQ-029 out_last = out_valid && state==DRAIN && drain_cnt==1.
REQ-030 No new grant while in DRAIN even if other channels request; other channels' req_valid held without loss.
REQ-031 Requests arriving in the same cycle as DRAIN->IDLE are considered in IDLE next cycle; minimum 1 IDLE cycle between bursts.
REQ-032 Channel deasserting req_valid while pending in IDLE: not granted; no state change.
REQ-033 burst_cnt width clog2(MAX_BURST+1); drain_cnt width clog2(DRAIN_CYCLES+1); no wrap possible.

Reset
REQ-034 On rst_n low, asynchronously: state=IDLE, owner=0, last_grant=NUM_CH-1 (channel 0 first), burst_cnt=0, drain_cnt=0; all outputs 0.
REQ-035 Reset mid-STREAM/DRAIN abandons the burst; no out_last generated; first grant after release follows REQ-034 pointer.

Verification
REQ-036 Single channel: ch1 sends 5 samples, 5th with last -> req_ready[1] high 5 accepts, flt_valid 5 cycles, then 17 DRAIN cycles, out_last once with out_chan=1, busy low after.
REQ-037 Round robin: all 4 channels request continuously with 3-sample bursts -> grant order 0,1,2,3,0; no interleaving within burst.
REQ-038 Forced end: ch2 streams 70 samples, no last, MAX_BURST=64 -> accepts exactly 64, DRAIN entered, ch2 re-granted later only after others with pending requests.
REQ-039 Bubbles: ch0 valid pattern 1,0,0,1(last) -> 2 accepts, flt_valid 1,0,0,1, stays STREAM through gaps.
REQ-040 Reset during DRAIN (drain_cnt=8) -> all outputs 0 immediately, busy 0, next grant to lowest requesting channel from 0.
REQ-041 Impulse: ch3 single sample 1 with last -> forwarded out_data sequence equals filter coefficients tagged out_chan=3.
